piso_tx_scheduler: RTL and testbench

Two-requester serial transmit scheduler that arbitrates parallel words from requesters A and B onto one shared parallel-in/serial-out shifter. It owns the load/shift sequencing, frame framing and inter-frame gap. It sits between the parallel producers and the single serial line. Each accepted word goes out MSB first, one bit per clock, tagged with its source.

---
 rtl/piso_tx_pkg.sv | 19 +
 rtl/piso_shifter.sv | 28 ++
 rtl/piso_tx_scheduler.sv | 127 ++++++++++++
 tb/tb_piso_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the two-requester serial transmit scheduler.
package piso_tx_pkg;

  // Scheduler states: waiting for a word, shifting a frame out, forced idle gap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Source identifiers, also used as the round-robin priority pointer value.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Default frame length and inter-frame gap.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_GAP   = 1;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in / serial-out shift register, MSB first, zero fill.
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] r_sh;

  // Load wins over shift; otherwise hold the current contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh <= '0;
    end else if (load) begin
      r_sh <= d;
    end else if (shift_en) begin
      r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign q = r_sh[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding words from requesters A and B into one
// serial shifter, with framing, frame-done pulse and inter-frame gap.
module piso_tx_scheduler
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_src,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW       = $clog2(WIDTH);
  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap;
  logic             r_prio;
  logic             r_src;

  logic             w_hs;
  logic             w_last_bit;
  logic             w_gap_end;
  logic             w_shift_q;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_load_data;

  assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
  assign w_gap_end   = (r_gap == GW'(GAP_LAST));
  assign w_hs        = a_ready | b_ready;
  assign w_shift_en  = (r_state == ST_SHIFT);
  assign w_load_data = b_ready ? b_data : a_data;

  assign busy    = (r_state != ST_IDLE);
  assign ser_src = r_src;

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_hs),
    .shift_en (w_shift_en),
    .d        (w_load_data),
    .q        (w_shift_q)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, arbitration (ready) and serial framing outputs.
  // Ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    w_state_next = r_state;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    ser_out      = 1'b0;
    ser_frame    = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        a_ready = !reset && a_valid && (!b_valid || (r_prio == SRC_A));
        b_ready = !reset && b_valid && (!a_valid || (r_prio == SRC_B));
        if (a_ready || b_ready) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_out   = w_shift_q;
        ser_frame = 1'b1;
        if (w_last_bit) begin
          frame_done   = 1'b1;
          w_state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Bit/gap counters, source tag and round-robin pointer.
  // The pointer moves to the side that lost (or did not ask) on every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_gap  <= '0;
      r_prio <= SRC_A;
      r_src  <= SRC_A;
    end else begin
      if (w_hs) begin
        r_cnt  <= '0;
        r_src  <= b_ready ? SRC_B : SRC_A;
        r_prio <= b_ready ? SRC_A : SRC_B;
      end else if (r_state == ST_SHIFT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == ST_SHIFT) begin
        r_gap <= '0;
      end else if (r_state == ST_GAP) begin
        r_gap <= r_gap + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler: three instances (4/1, 4/0, 8/1).
module tb_piso_tx_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  // WIDTH=4, GAP=1 instance
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, ser_out, ser_frame, ser_src, frame_done, busy;

  // WIDTH=4, GAP=0 instance
  logic       z_a_valid = 1'b0, z_b_valid = 1'b0;
  logic [3:0] z_a_data = '0, z_b_data = '0;
  logic       z_a_ready, z_b_ready, z_ser_out, z_ser_frame, z_ser_src, z_frame_done, z_busy;

  // WIDTH=8, GAP=1 instance
  logic       e_a_valid = 1'b0, e_b_valid = 1'b0;
  logic [7:0] e_a_data = '0, e_b_data = '0;
  logic       e_a_ready, e_b_ready, e_ser_out, e_ser_frame, e_ser_src, e_frame_done, e_busy;

  int checks = 0;
  int errors = 0;

  piso_tx_scheduler #(.WIDTH(4), .GAP(1)) u_dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .ser_out(ser_out), .ser_frame(ser_frame), .ser_src(ser_src),
    .frame_done(frame_done), .busy(busy)
  );

  piso_tx_scheduler #(.WIDTH(4), .GAP(0)) u_dut_g0 (
    .clk(clk), .reset(reset),
    .a_valid(z_a_valid), .a_data(z_a_data), .a_ready(z_a_ready),
    .b_valid(z_b_valid), .b_data(z_b_data), .b_ready(z_b_ready),
    .ser_out(z_ser_out), .ser_frame(z_ser_frame), .ser_src(z_ser_src),
    .frame_done(z_frame_done), .busy(z_busy)
  );

  piso_tx_scheduler #(.WIDTH(8), .GAP(1)) u_dut_w8 (
    .clk(clk), .reset(reset),
    .a_valid(e_a_valid), .a_data(e_a_data), .a_ready(e_a_ready),
    .b_valid(e_b_valid), .b_data(e_b_data), .b_ready(e_b_ready),
    .ser_out(e_ser_out), .ser_frame(e_ser_frame), .ser_src(e_ser_src),
    .frame_done(e_frame_done), .busy(e_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] w4;
  logic [7:0] w8;
  logic       src_exp;

  initial begin
    // ---- reset state ----
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_frame", ser_frame, 0);
    check("rst_out", ser_out, 0);
    check("rst_done", frame_done, 0);
    check("rst_src", ser_src, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_z_busy", z_busy, 0);
    check("rst_e_busy", e_busy, 0);
    reset = 1'b0;

    // ---- single A frame, word 1011 ----
    a_valid = 1'b1; a_data = 4'b1011; w4 = 4'b1011;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_b_ready", b_ready, 0);
    check("t1_idle_busy", busy, 0);
    tick();
    a_valid = 1'b0; a_data = 4'h0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check("t1_frame", ser_frame, 1);
      check("t1_bit", ser_out, w4[3-k]);
      check("t1_done", frame_done, (k == 3));
      check("t1_src", ser_src, 0);
      check("t1_a_ready_busy", a_ready, 0);
    end
    $display("frame A word=%h", w4);
    tick();
    check("t1_gap_frame", ser_frame, 0);
    check("t1_gap_busy", busy, 1);
    check("t1_gap_done", frame_done, 0);
    tick();
    check("t1_idle_again", busy, 0);

    // ---- A and B together from reset: A,B,A,B with 2 low cycles each ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      a_data = (f < 2) ? 4'hA : 4'hC;
      b_data = (f < 2) ? 4'h5 : 4'h3;
      src_exp = f[0];
      w4 = src_exp ? b_data : a_data;
      #1;
      check("t2_a_ready", a_ready, !src_exp);
      check("t2_b_ready", b_ready, src_exp);
      check("t2_idle_frame", ser_frame, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) tick();
        check("t2_frame", ser_frame, 1);
        check("t2_src", ser_src, src_exp);
        check("t2_bit", ser_out, w4[3-k]);
        check("t2_done", frame_done, (k == 3));
        check("t2_ready_shift", {a_ready, b_ready}, 0);
      end
      $display("frame %0d src=%0d word=%h", f, src_exp, w4);
      tick();
      check("t2_gap_frame", ser_frame, 0);
      check("t2_gap_ready", {a_ready, b_ready}, 0);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("t2_src_hold", ser_src, 1);
    check("t2_end_busy", busy, 0);

    // ---- GAP=0, B continuously valid: back-to-back frames ----
    z_b_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      z_b_data = (f == 0) ? 4'b0110 : ((f == 1) ? 4'b1001 : 4'b1111);
      w4 = z_b_data;
      #1;
      check("t3_b_ready", z_b_ready, 1);
      check("t3_idle_frame", z_ser_frame, 0);
      check("t3_idle_busy", z_busy, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) tick();
        check("t3_frame", z_ser_frame, 1);
        check("t3_src", z_ser_src, 1);
        check("t3_bit", z_ser_out, w4[3-k]);
        check("t3_done", z_frame_done, (k == 3));
        check("t3_b_ready_shift", z_b_ready, 0);
      end
      $display("g0 frame %0d src=1 word=%h", f, w4);
      tick();
    end
    z_b_valid = 1'b0;

    // ---- reset during bit 2 of an A frame ----
    a_valid = 1'b1; a_data = 4'b1100;
    #1;
    check("t4_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("t4_bit0", ser_out, 1);
    tick();
    check("t4_bit1", ser_out, 1);
    tick();
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("t4_rst_frame", ser_frame, 0);
    check("t4_rst_out", ser_out, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", frame_done, 0);
    check("t4_rst_src", ser_src, 0);
    check("t4_rst_ready", {a_ready, b_ready}, 0);
    tick();
    check("t4_rst_hold_done", frame_done, 0);
    check("t4_rst_hold_busy", busy, 0);
    reset = 1'b0; a_data = 4'b0111;
    #1;
    check("t4_prio_a_ready", a_ready, 1);
    check("t4_prio_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t4_src", ser_src, 0);
    check("t4_frame", ser_frame, 1);
    check("t4_first_bit", ser_out, 0);
    repeat (5) tick();
    check("t4_drained", busy, 0);

    // ---- A valid raised while busy and dropped: no frame ----
    b_valid = 1'b1; b_data = 4'h9;
    #1;
    check("t5_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0; a_valid = 1'b1;
    #1;
    check("t5_a_ready_shift", a_ready, 0);
    repeat (2) tick();
    a_valid = 1'b0;
    repeat (3) tick();
    check("t5_idle_a_ready", a_ready, 0);
    check("t5_idle_busy", busy, 0);
    tick();
    check("t5_no_frame", ser_frame, 0);
    check("t5_no_busy", busy, 0);
    // ---- raised during SHIFT: accepted in the first IDLE cycle ----
    b_valid = 1'b1; b_data = 4'h6;
    #1;
    tick();
    b_valid = 1'b0;
    tick();
    a_valid = 1'b1; a_data = 4'b0101; w4 = 4'b0101;
    #1;
    check("t5b_a_ready_shift", a_ready, 0);
    repeat (3) tick();
    check("t5b_gap_a_ready", a_ready, 0);
    check("t5b_gap_busy", busy, 1);
    tick();
    check("t5b_idle_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("t5b_frame", ser_frame, 1);
    check("t5b_src", ser_src, 0);
    check("t5b_bit", ser_out, w4[3]);
    repeat (5) tick();

    // ---- WIDTH=8, word 8'h81 ----
    e_a_valid = 1'b1; e_a_data = 8'h81; w8 = 8'h81;
    #1;
    check("t6_a_ready", e_a_ready, 1);
    tick();
    e_a_valid = 1'b0; e_a_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check("t6_frame", e_ser_frame, 1);
      check("t6_bit", e_ser_out, w8[7-k]);
      check("t6_done", e_frame_done, (k == 7));
      check("t6_src", e_ser_src, 0);
    end
    $display("w8 frame src=0 word=%h", w8);
    tick();
    check("t6_gap_frame", e_ser_frame, 0);
    check("t6_gap_busy", e_busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
